// File: rtl/predlogic.sv
// predlogic -- conditional-execution / predicated-block control.
//
// Evaluates an ARM-style condition code against the architectural flags and
// gates the PC write and the architectural write enables with the registered
// result. A small FSM runs predicated blocks: after a valid ITStart, each
// following instruction takes its condition from the latched block condition.
// The condition LSB is flipped for slots whose mask bit is 0.
//
// Optional feature: define PREDLOGIC_QFLAG_EN to add a sticky saturation flag.
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   Cond[3:0]        condition of the current instruction
//   ALUFlags[3:0]    {N,Z,C,V} produced by the ALU
//   FlagW[1:0]       flag write request ([1] -> N,Z ; [0] -> C,V)
//   PCS, NextPC      conditional PC write request, unconditional PC advance
//   W[NCH-1:0]       raw write requests (bit0 RegW, bit1 MemW, ...)
//   ITStart          pulse opening a predicated block
//   ITCond/ITMask/ITLen  block base condition, per-slot polarity, length
//   InstrDone        pulse retiring the current instruction
//   PCWrite          gated PC write
//   Write[NCH-1:0]   gated write enables
//   Flags[3:0]       architectural {N,Z,C,V}
//   ITActive         predicated block in progress
//   ITErr            one-cycle pulse (cycle after the request) on a rejected ITStart
//   ALUSat, QClr, QFlag  (PREDLOGIC_QFLAG_EN only) saturation set, clear, sticky flag
module predlogic #(
    parameter int NCH      = 4,
    parameter int IT_DEPTH = 4,
    localparam int LW      = $clog2(IT_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          Cond,
    input  logic [3:0]          ALUFlags,
    input  logic [1:0]          FlagW,
    input  logic                PCS,
    input  logic                NextPC,
    input  logic [NCH-1:0]      W,
    input  logic                ITStart,
    input  logic [3:0]          ITCond,
    input  logic [IT_DEPTH-1:0] ITMask,
    input  logic [LW-1:0]       ITLen,
    input  logic                InstrDone,
`ifdef PREDLOGIC_QFLAG_EN
    input  logic                ALUSat,
    input  logic                QClr,
    output logic                QFlag,
`endif
    output logic                PCWrite,
    output logic [NCH-1:0]      Write,
    output logic [3:0]          Flags,
    output logic                ITActive,
    output logic                ITErr
);

    localparam logic [LW-1:0] ONE     = LW'(1);
    localparam logic [LW-1:0] DEPTH_L = LW'(IT_DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state, state_nxt;
    logic [LW-1:0]         slot, slot_nxt;
    logic [3:0]            it_cond;
    logic [IT_DEPTH-1:0]   it_mask;
    logic [LW-1:0]         it_len;
    logic                  latch_en, err_nxt;
    logic                  cond_ex, cond_exfl;
    logic [3:0]            eff_cond;
    logic [IT_DEPTH-1:0]   mask_sh;
    logic                  len_ok;
    logic                  n, z, c, v;

    assign ITActive = (state == ACTIVE);
    assign len_ok   = (ITLen != '0) && (ITLen <= DEPTH_L);

    // Mask bit for the current slot; shifting avoids an index wider than the mask.
    assign mask_sh  = it_mask >> slot;
    assign eff_cond = ITActive ? {it_cond[3:1], it_cond[0] ^ ~mask_sh[0]} : Cond;

    assign {n, z, c, v} = Flags;

    always_comb begin
        cond_ex = 1'b1;
        case (eff_cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~(c & ~z);
            4'b1010: cond_ex = ~(n ^ v);
            4'b1011: cond_ex = n ^ v;
            4'b1100: cond_ex = ~z & ~(n ^ v);
            4'b1101: cond_ex = ~(~z & ~(n ^ v));
            default: cond_ex = 1'b1;   // AL, and 1111 (an inverted AL slot)
        endcase
    end

    assign PCWrite = NextPC | (PCS & cond_exfl);
    assign Write   = W & {NCH{cond_exfl}};

    // Block control: ITStart always takes priority over InstrDone in IDLE;
    // in ACTIVE a second ITStart is only reported, retirement keeps going.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        latch_en  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (ITStart) begin
                    if (len_ok) begin
                        state_nxt = ACTIVE;
                        slot_nxt  = '0;
                        latch_en  = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (ITStart) err_nxt = 1'b1;
                if (InstrDone) begin
                    if (slot == it_len - ONE) begin
                        state_nxt = IDLE;
                        slot_nxt  = '0;
                    end else begin
                        slot_nxt  = slot + ONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            slot      <= '0;
            it_cond   <= '0;
            it_mask   <= '0;
            it_len    <= '0;
            ITErr     <= 1'b0;
            cond_exfl <= 1'b0;
            Flags     <= '0;
        end else begin
            state     <= state_nxt;
            slot      <= slot_nxt;
            ITErr     <= err_nxt;
            cond_exfl <= cond_ex;
            if (latch_en) begin
                it_cond <= ITCond;
                it_mask <= ITMask;
                it_len  <= ITLen;
            end
            if (FlagW[1] && cond_ex) Flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0] && cond_ex) Flags[1:0] <= ALUFlags[1:0];
        end
    end

`ifdef PREDLOGIC_QFLAG_EN
    // Sticky saturation flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                QFlag <= 1'b0;
        else if (ALUSat && cond_ex) QFlag <= 1'b1;
        else if (QClr)             QFlag <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_predlogic.sv
module tb_predlogic;
    localparam int NCH      = 4;
    localparam int IT_DEPTH = 4;
    localparam int LW       = $clog2(IT_DEPTH + 1);

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [3:0]          Cond, ALUFlags, ITCond;
    logic [1:0]          FlagW;
    logic                PCS, NextPC, ITStart, InstrDone;
    logic [NCH-1:0]      W;
    logic [IT_DEPTH-1:0] ITMask;
    logic [LW-1:0]       ITLen;
    logic                PCWrite, ITActive, ITErr;
    logic [NCH-1:0]      Write;
    logic [3:0]          Flags;
`ifdef PREDLOGIC_QFLAG_EN
    logic                ALUSat, QClr, QFlag;
`endif

    predlogic #(.NCH(NCH), .IT_DEPTH(IT_DEPTH)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .NextPC(NextPC), .W(W), .ITStart(ITStart), .ITCond(ITCond),
        .ITMask(ITMask), .ITLen(ITLen), .InstrDone(InstrDone),
`ifdef PREDLOGIC_QFLAG_EN
        .ALUSat(ALUSat), .QClr(QClr), .QFlag(QFlag),
`endif
        .PCWrite(PCWrite), .Write(Write), .Flags(Flags), .ITActive(ITActive), .ITErr(ITErr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Predicated block held as a queue of per-slot condition codes; the block
    // is active while the queue is non-empty.
    logic [3:0] m_flags = 4'h0;
    logic       m_cexfl = 1'b0;
    logic       m_err   = 1'b0;
    logic       m_q     = 1'b0;
    logic [3:0] m_blk[$];

    function automatic logic cond_true(input logic [3:0] code, input logic [3:0] f);
        logic fn, fz, fc, fv, base;
        fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
        case (code[3:1])
            3'd0: base = fz;
            3'd1: base = fc;
            3'd2: base = fn;
            3'd3: base = fv;
            3'd4: base = fc && !fz;
            3'd5: base = (fn == fv);
            3'd6: base = !fz && (fn == fv);
            default: return 1'b1;
        endcase
        return base ^ code[0];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_flags = 4'h0; m_cexfl = 1'b0; m_err = 1'b0; m_q = 1'b0;
            m_blk.delete();
        end else begin
            logic act, ce;
            logic [IT_DEPTH-1:0] msk;
            act = (m_blk.size() != 0);
            ce  = cond_true(act ? m_blk[0] : Cond, m_flags);
            if (FlagW[1] && ce) m_flags[3:2] = ALUFlags[3:2];
            if (FlagW[0] && ce) m_flags[1:0] = ALUFlags[1:0];
`ifdef PREDLOGIC_QFLAG_EN
            if (ALUSat && ce) m_q = 1'b1;
            else if (QClr)    m_q = 1'b0;
`endif
            m_cexfl = ce;
            m_err   = 1'b0;
            if (act && InstrDone) void'(m_blk.pop_front());
            if (ITStart) begin
                if (!act && int'(ITLen) >= 1 && int'(ITLen) <= IT_DEPTH) begin
                    for (int i = 0; i < int'(ITLen); i++) begin
                        msk = ITMask >> i;
                        m_blk.push_back({ITCond[3:1], ITCond[0] ^ !msk[0]});
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("PCWrite",  32'(PCWrite),  32'(NextPC | (PCS & m_cexfl)));
        chk("Write",    32'(Write),    32'(W & {NCH{m_cexfl}}));
        chk("Flags",    32'(Flags),    32'(m_flags));
        chk("ITActive", 32'(ITActive), 32'(m_blk.size() != 0));
        chk("ITErr",    32'(ITErr),    32'(m_err));
`ifdef PREDLOGIC_QFLAG_EN
        chk("QFlag",    32'(QFlag),    32'(m_q));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        Cond = 4'hE; FlagW = 2'b11; ALUFlags = f;
        step();
        FlagW = 2'b00;
    endtask

    logic [3:0] pats [6] = '{4'b0000, 4'b0100, 4'b1001, 4'b0010, 4'b1010, 4'b0110};

    initial begin
        Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00; PCS = 1'b0; NextPC = 1'b0;
        W = '0; ITStart = 1'b0; ITCond = 4'h0; ITMask = '0; ITLen = '0; InstrDone = 1'b0;
`ifdef PREDLOGIC_QFLAG_EN
        ALUSat = 1'b0; QClr = 1'b0;
`endif
        // reset behaviour
        W = '1; NextPC = 1'b1; Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'hF;
        step();
        chk("rst_write", 32'(Write), 32'h0);
        chk("rst_pcwrite_next", 32'(PCWrite), 32'h1);
        chk("rst_flags", 32'(Flags), 32'h0);
        chk("rst_itactive", 32'(ITActive), 32'h0);
        NextPC = 1'b0; PCS = 1'b1;
        step();
        chk("rst_pcwrite_pcs", 32'(PCWrite), 32'h0);
        reset = 1'b1; W = '0; PCS = 1'b0; FlagW = 2'b00;

        // flags load and write gating
        FlagW = 2'b11; Cond = 4'hE; ALUFlags = 4'b0100;
        step();
        chk("flag_load", 32'(Flags), 32'h4);
        FlagW = 2'b00; Cond = 4'h0; W = 4'b0011;
        step();
        chk("eq_write", 32'(Write), 32'h3);

        // failing EQ blocks flag write and PC write
        set_flags(4'b0000);
        Cond = 4'h0; FlagW = 2'b11; ALUFlags = 4'hF; PCS = 1'b1; W = '0;
        step();
        chk("eq_fail_flags", 32'(Flags), 32'h0);
        chk("eq_fail_pcwrite", 32'(PCWrite), 32'h0);
        FlagW = 2'b00; PCS = 1'b0;

        // condition sweep over several flag patterns
        foreach (pats[p]) begin
            set_flags(pats[p]);
            for (int cc = 0; cc < 16; cc++) begin
                Cond = 4'(cc); W = 4'b1011; PCS = 1'b1;
                step();
            end
        end
        PCS = 1'b0; W = '0;

        // 3-slot block: EQ, NE, EQ with Z=1 -> 1,0,1
        set_flags(4'b0100);
        ITStart = 1'b1; ITCond = 4'h0; ITMask = 4'b0101; ITLen = 3'd3; Cond = 4'h1; W = 4'b0001;
        step();
        ITStart = 1'b0;
        chk("it_active_start", 32'(ITActive), 32'h1);
        InstrDone = 1'b1;
        step(); chk("it_slot0", 32'(Write), 32'h1);
        step(); chk("it_slot1", 32'(Write), 32'h0);
        step(); chk("it_slot2", 32'(Write), 32'h1);
        chk("it_done", 32'(ITActive), 32'h0);
        InstrDone = 1'b0;

        // rejected starts
        ITStart = 1'b1; ITLen = 3'd0;
        step(); ITStart = 1'b0;
        chk("err_len0", 32'(ITErr), 32'h1);
        chk("err_len0_idle", 32'(ITActive), 32'h0);
        step(); chk("err_pulse_one", 32'(ITErr), 32'h0);
        ITStart = 1'b1; ITLen = 3'd5;
        step(); ITStart = 1'b0;
        chk("err_len5", 32'(ITErr), 32'h1);

        // ITStart inside a running block is reported, sequence unaffected
        ITStart = 1'b1; ITCond = 4'h0; ITMask = 4'b0101; ITLen = 3'd3;
        step(); ITStart = 1'b0; InstrDone = 1'b1;
        step(); chk("nest_slot0", 32'(Write), 32'h1);
        ITStart = 1'b1; ITCond = 4'h1; ITMask = 4'b0000; ITLen = 3'd2;
        step(); ITStart = 1'b0;
        chk("nest_err", 32'(ITErr), 32'h1);
        chk("nest_slot1", 32'(Write), 32'h0);
        step();
        chk("nest_slot2", 32'(Write), 32'h1);
        chk("nest_done", 32'(ITActive), 32'h0);
        InstrDone = 1'b0;

        // ITStart and InstrDone together in IDLE: start wins
        ITStart = 1'b1; InstrDone = 1'b1; ITCond = 4'hA; ITMask = 4'b0011; ITLen = 3'd2;
        step(); ITStart = 1'b0; InstrDone = 1'b0;
        chk("idle_start_wins", 32'(ITActive), 32'h1);
        step(); InstrDone = 1'b1;
        step(); step(); InstrDone = 1'b0;
        step();

        // full-depth block with gaps and flag updates inside
        set_flags(4'b1000);
        ITStart = 1'b1; ITCond = 4'hA; ITMask = 4'b1010; ITLen = 3'd4; W = 4'b1111;
        step(); ITStart = 1'b0;
        for (int s = 0; s < 4; s++) begin
            step();
            InstrDone = 1'b1; FlagW = (s == 2) ? 2'b11 : 2'b00; ALUFlags = 4'b0001;
            step();
            InstrDone = 1'b0; FlagW = 2'b00;
        end
        step();
        chk("depth_done", 32'(ITActive), 32'h0);

        // reset in the middle of a 4-slot block
        set_flags(4'b0100);
        ITStart = 1'b1; ITCond = 4'h0; ITMask = 4'b1111; ITLen = 3'd4; W = 4'b0001;
        step(); ITStart = 1'b0; InstrDone = 1'b1;
        step(); InstrDone = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_itactive", 32'(ITActive), 32'h0);
        chk("mid_rst_flags", 32'(Flags), 32'h0);
        chk("mid_rst_write", 32'(Write), 32'h0);
        step();
        reset = 1'b1;
        step();
        chk("mid_rst_no_resume", 32'(ITActive), 32'h0);

`ifdef PREDLOGIC_QFLAG_EN
        Cond = 4'hE; ALUSat = 1'b1; QClr = 1'b1;
        step();
        chk("q_set_wins", 32'(QFlag), 32'h1);
        ALUSat = 1'b0;
        step();
        chk("q_clear", 32'(QFlag), 32'h0);
        QClr = 1'b0;
`endif
        step();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/predlogic.md
PREDLOGIC -- requirements
Module: predlogic

Interface
REQ-001 Parameter NCH, default 4, number of gated architectural write-enable channels (1..8).
REQ-002 Parameter IT_DEPTH, default 4, maximum predicated-block length (1..8); LW = $clog2(IT_DEPTH+1).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Cond  input  4  condition field of the current instruction.
REQ-006 ALUFlags  input  4  {N,Z,C,V} from the ALU.
REQ-007 FlagW  input  2  flag write request; [1] covers N,Z and [0] covers C,V.
REQ-008 PCS  input  1  instruction writes the PC.
REQ-009 NextPC  input  1  unconditional PC advance.
REQ-010 W  input  NCH  raw write requests; bit 0 is RegW, bit 1 is MemW, higher bits are user-defined.
REQ-011 ITStart  input  1  one-cycle pulse that opens a predicated block.
REQ-012 ITCond  input  4  base condition for the block.
REQ-013 ITMask  input  IT_DEPTH  per-slot polarity; bit i=1 uses ITCond, bit i=0 uses the inverse of ITCond.
REQ-014 ITLen  input  LW  block length, in instructions.
REQ-015 InstrDone  input  1  one-cycle pulse marking retirement of the current instruction.
REQ-016 PCWrite  output  1  gated PC write.
REQ-017 Write  output  NCH  gated write enables.
REQ-018 Flags  output  4  architectural {N,Z,C,V}.
REQ-019 ITActive  output  1  a predicated block is in progress.
REQ-020 ITErr  output  1  one-cycle pulse flagging a rejected ITStart.

Function
REQ-021 Effective condition: ITCond with its LSB inverted per the ITMask slot bit while ITActive; otherwise Cond.
REQ-022 Condition evaluation SHALL follow ARM encodings 0000..1110 (EQ..AL) against the registered Flags.
REQ-023 Code 1111 SHALL evaluate true; this covers an inverted AL.
REQ-024 CondEx is combinational; CondExFl SHALL register CondEx on every rising clk edge.
REQ-025 Flags[3:2] SHALL load ALUFlags[3:2] only when FlagW[1]&CondEx, and Flags[1:0] only when FlagW[0]&CondEx.
REQ-026 PCWrite SHALL equal NextPC | (PCS & CondExFl).
REQ-027 Write[i] SHALL equal W[i] & CondExFl.
REQ-028 The FSM SHALL have two states, IDLE and ACTIVE; ITActive=1 exactly in ACTIVE.
REQ-029 IDLE->ACTIVE on ITStart with 1<=ITLen<=IT_DEPTH: latch ITCond, ITMask and ITLen; set slot index to 0.
REQ-030 ITStart with ITLen=0 or ITLen>IT_DEPTH SHALL be ignored and SHALL pulse ITErr.
REQ-031 In ACTIVE, each InstrDone SHALL increment the slot index; the InstrDone that retires slot ITLen-1 SHALL return the FSM to IDLE on that edge.
REQ-032 ITStart in ACTIVE SHALL be ignored and SHALL pulse ITErr for one cycle; the block continues unaffected.
REQ-033 ITStart and InstrDone in the same IDLE cycle: ITStart wins; InstrDone has no effect.
REQ-034 The first predicated instruction is the one following the ITStart cycle.
REQ-035 The slot index SHALL never exceed IT_DEPTH-1; the counter SHALL NOT wrap while in ACTIVE.

Reset
REQ-036 While reset=0: Flags=0000, CondExFl=0, FSM=IDLE, slot index=0, latched ITCond/ITMask/ITLen=0, ITErr=0.
REQ-037 Consequently PCWrite=NextPC and Write=0 during reset.
REQ-038 Reset asserted mid-block SHALL abort the block immediately; no retirement state is retained.

Configuration
REQ-039 Macro PREDLOGIC_QFLAG_EN defined adds input ALUSat(1), input QClr(1) and output QFlag(1).
REQ-040 With PREDLOGIC_QFLAG_EN, QFlag SHALL set when ALUSat&CondEx, and clear when QClr.
REQ-041 With PREDLOGIC_QFLAG_EN, QFlag set SHALL win over a simultaneous QClr, and QFlag SHALL reset to 0.
REQ-042 Macro undefined: the ALUSat, QClr and QFlag ports are absent; all other behaviour is identical.

Verification
REQ-043 Reset, then FlagW=11, Cond=1110, ALUFlags=0100 -> Flags=0100 next edge; Cond=0000 with W=0011 -> Write=0011 one cycle later.
REQ-044 Flags Z=0, Cond=0000 (EQ), FlagW=11, ALUFlags=1111 -> Flags unchanged; PCS=1 -> PCWrite=0.
REQ-045 ITStart, ITCond=0000, ITMask=0101, ITLen=3, Z=1; three InstrDone -> slot CondExFl=1,0,1; ITActive drops after the third InstrDone.
REQ-046 ITStart with ITLen=0 -> ITErr=1 for one cycle, ITActive=0; ITStart during ACTIVE -> ITErr pulse, slot sequence unchanged.
REQ-047 reset=0 at slot 1 of a 4-slot block -> ITActive=0 and Flags=0000 immediately; CondExFl=0.
REQ-048 PREDLOGIC_QFLAG_EN: ALUSat=1 with QClr=1 in the same cycle under a passing condition -> QFlag=1; QClr alone -> QFlag=0.
